// File: rtl/nibble_sum_collector_pkg.sv
// Shared definitions for the nibble sum collector.
//   NIBBLE_W         width of one adder slice sum
//   NIBBLES_DEFAULT  default number of slices per assembled word
//   state_t          collector FSM states
package nibble_sum_collector_pkg;

    localparam int NIBBLE_W        = 4;
    localparam int NIBBLES_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        HOLD    = 2'd2
    } state_t;

endpackage

// File: rtl/nibble_sum_collector.sv
// Collects 4-bit adder slice results (sum nibble + carry-out) into one word.
// Slice 0 lands in bits [3:0]. A word completes on in_last or when all
// NIBBLES slots are filled. It is then held with out_valid until out_ready.
//
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   in_valid   slice present           in_ready   slice accepted this cycle
//   in_s       slice sum nibble        in_cout    slice carry-out
//   in_last    final slice of word
//   out_valid  assembled word held     out_ready  downstream takes word
//   out_word   assembled sum           out_carry  carry of final slice
//   out_count  slices in held word
module nibble_sum_collector
    import nibble_sum_collector_pkg::*;
#(
    parameter int NIBBLES = NIBBLES_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [NIBBLE_W-1:0]   in_s,
    input  logic                  in_cout,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*NIBBLES-1:0]  out_word,
    output logic                  out_carry,
    output logic [3:0]            out_count
);

    localparam logic [3:0] LAST_IDX = 4'(NIBBLES - 1);

    state_t state, state_nx;

    logic [NIBBLES-1:0][NIBBLE_W-1:0] slots;
    logic [3:0] cnt;
    logic [3:0] idx;
    logic       accept;
    logic       final_slice;

    // The slice counter keeps its old value through IDLE; the first slice of
    // a new word always goes to slot 0.
    assign idx         = (state == IDLE) ? 4'd0 : cnt;
    assign accept      = in_valid && in_ready;
    assign final_slice = in_last || (idx == LAST_IDX);

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE, COLLECT: begin
                if (accept) state_nx = final_slice ? HOLD : COLLECT;
            end
            HOLD: begin
                if (out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE, COLLECT: in_ready  = 1'b1;
            HOLD:          out_valid = 1'b1;
            default:       ;
        endcase
    end

    // Slot file, counter and held result. The slot file doubles as the
    // output word, so it keeps the last delivered word until the first slice
    // of the next word clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            slots     <= '0;
            cnt       <= '0;
            out_carry <= 1'b0;
            out_count <= '0;
        end else if (accept) begin
            for (int unsigned i = 0; i < NIBBLES; i++) begin
                if (4'(i) == idx)
                    slots[i] <= in_s;
                else if (state == IDLE)
                    slots[i] <= '0;
            end
            cnt <= idx + 4'd1;
            if (final_slice) begin
                out_carry <= in_cout;
                out_count <= idx + 4'd1;
            end
        end
    end

    assign out_word = slots;

endmodule

// File: doc/nibble_sum_collector.md
NIBBLE_SUM_COLLECTOR -- requirements
Module: nibble_sum_collector

Interface
REQ-001 SHALL have parameter: NIBBLES, 4, number of 4-bit sum slices assembled into one result word (range 2..8).
REQ-002 SHALL have port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port: in_valid  input  1  upstream adder slice result (sum, carry) present.
REQ-005 SHALL have port: in_ready  output  1  block accepts a slice this cycle.
REQ-006 SHALL have port: in_s  input  4  sum nibble from the 4-bit adder stage.
REQ-007 SHALL have port: in_cout  input  1  carry-out of that adder slice (its c[3]).
REQ-008 SHALL have port: in_last  input  1  this slice is the final one of the word.
REQ-009 SHALL have port: out_valid  output  1  assembled word available.
REQ-010 SHALL have port: out_ready  input  1  downstream consumes the word.
REQ-011 SHALL have port: out_word  output  4*NIBBLES  assembled sum, slice 0 in bits [3:0].
REQ-012 SHALL have port: out_carry  output  1  carry-out of the final accepted slice.
REQ-013 SHALL have port: out_count  output  4  number of slices in the held word.

Function
REQ-014 SHALL implement states IDLE, COLLECT, HOLD; IDLE after reset.
REQ-015 SHALL drive in_ready=1 in IDLE and COLLECT, 0 in HOLD.
REQ-016 SHALL accept a slice only when in_valid && in_ready on a rising edge.
REQ-017 SHALL write each accepted in_s into slot index = slices accepted so far (LSB slot first).
REQ-018 SHALL clear all slots to zero on the first acceptance in IDLE, so unused upper slots of short words read 0.
REQ-019 IDLE -> COLLECT on acceptance with in_last=0 and NIBBLES>1.
REQ-020 IDLE/COLLECT -> HOLD on acceptance with in_last=1, or on acceptance of slot NIBBLES-1 regardless of in_last.
REQ-021 SHALL latch out_carry from in_cout of the slice that causes the HOLD transition; carries of earlier slices are discarded.
REQ-022 SHALL assert out_valid exactly in HOLD; first out_valid cycle is the cycle after the final slice acceptance (latency 1).
REQ-023 SHALL keep out_word, out_carry, out_count stable throughout HOLD.
REQ-024 HOLD -> IDLE when out_ready=1; out_valid deasserts next cycle; no slice accepted in that same cycle.
REQ-025 SHALL tolerate in_valid gaps in COLLECT: state, slots and count unchanged while in_valid=0.
REQ-026 SHALL leave out_word/out_carry/out_count holding the last delivered values in IDLE and COLLECT until the next HOLD entry, except cleared by REQ-018 and reset.
REQ-027 SHALL make out_count equal the accepted slice count (1..NIBBLES) of the held word.

Reset
REQ-028 rst SHALL take priority over all other inputs on the same edge.
REQ-029 On rst: state=IDLE, slots=0, slice count=0, out_word=0, out_carry=0, out_count=0, out_valid=0; in_ready=1 from the first cycle after rst deasserts.
REQ-030 rst mid-word or in HOLD SHALL discard the partial/held word with no out_valid pulse.

Structure
REQ-031 Shared package SHALL hold the state enumeration, NIBBLE_W=4 and default NIBBLES constant.
REQ-032 No sub-module; slot register file, counter and FSM SHALL be in this module.

Verification
REQ-033 NIBBLES=4, slices 0x1/0x2/0x3/0x4, couts 0/0/0/1, in_last on 4th -> out_valid cycle after 4th accept, out_word=0x4321, out_carry=1, out_count=4.
REQ-034 Single slice 0xA, in_last=1, cout=0 -> out_word=0x000A, out_carry=0, out_count=1.
REQ-035 Word held, out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, outputs unchanged; out_ready=1 -> IDLE, in_ready=1 next cycle.
REQ-036 rst after 2 of 4 slices (0xF, 0xF) -> all outputs 0, no out_valid; next word 0x5/0x6/0x7/0x8 -> 0x8765.
REQ-037 Slices 0x3,gap 2 cycles,0xC,in_last -> out_word=0x00C3, out_count=2.
REQ-038 5 slices presented, in_last never set -> HOLD after 4th; 5th not accepted until out_ready, then starts new word.
